slink_ll_rx_pkt_deframer: RTL
=============================

SLINK_LL_RX_PKT_DEFRAMER -- requirements
Module: slink_ll_rx_pkt_deframer

Interface
REQ-001 SHALL have parameter SHORT_PKT_MAX_ID, default 8'h1F, meaning a data_id at or below this value is a short packet (no payload, no CRC).
REQ-002 SHALL have parameter MAX_WORD_COUNT, default 16'd4096, meaning the largest long-packet payload length accepted, in bytes.
REQ-003 SHALL have port clk, input, 1, the single block clock.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port link_data, input, 8, the deskewed RX byte stream.
REQ-006 SHALL have port link_valid, input, 1, qualifying link_data; low stalls the block with all state held.
REQ-007 SHALL have outputs sop (1), data_id (8), word_count (16), valid (1), data (8), eop (1): the packet stream consumed by the downstream packet filter.
REQ-008 SHALL have outputs hdr_err (1) and crc_err (1), each a one-cycle error pulse.

Function
REQ-009 Header format SHALL be 4 bytes in this order: data_id, wc[7:0], wc[15:8], ecc, where ecc = data_id ^ wc[7:0] ^ wc[15:8].
REQ-010 The FSM SHALL have states HDR0, HDR1, HDR2, HDR3, PAYLOAD, CRC0, CRC1; a state advances only on a cycle with link_valid=1.
REQ-011 HDR0->HDR1->HDR2->HDR3 SHALL capture data_id, wc_lo and wc_hi, then compare ecc in HDR3.
REQ-012 In HDR3, an ecc mismatch, or a long packet with wc > MAX_WORD_COUNT, SHALL pulse hdr_err the next cycle, emit no sop, and return to HDR0.
REQ-013 A good short header SHALL, the next cycle, pulse sop=valid=eop=1 with data=8'h00, data_id latched and word_count=wc (payload field), then return to HDR0.
REQ-014 A good long header with wc>0 SHALL go to PAYLOAD.
REQ-015 A good long header with wc=0 SHALL go to CRC0; after CRC1 it SHALL pulse sop=valid=eop=1 with data=8'h00.
REQ-016 In PAYLOAD, each accepted byte SHALL appear on data with valid=1 exactly one cycle later.
REQ-017 In PAYLOAD, sop SHALL be set on the first payload byte only and eop on byte number wc only.
REQ-018 A 16-bit down-counter SHALL load wc in HDR3 and decrement per accepted payload byte; PAYLOAD->CRC0 occurs when the counter reaches 1 and a byte is accepted.
REQ-019 CRC SHALL be CRC-16/CCITT (poly 0x1021, init 16'hFFFF, MSB-first, no final XOR) over payload bytes only.
REQ-020 The CRC SHALL be reinitialised in HDR3.
REQ-021 CRC0/CRC1 SHALL receive the CRC bytes low byte first.
REQ-022 On a CRC mismatch, crc_err SHALL pulse one cycle after the CRC1 byte is accepted; payload already output is not retracted.
REQ-023 After CRC1 the FSM SHALL return to HDR0; back-to-back packets with no gap bytes SHALL be supported.
REQ-024 data_id and word_count SHALL be registered, updated only in HDR3 on a good header, and held until the next good header.
REQ-025 valid, sop, eop, hdr_err and crc_err SHALL be registered and default to 0 in every cycle not named above.
REQ-026 When link_valid=0, valid, sop and eop SHALL be 0 the next cycle; the counter, CRC and FSM state SHALL hold.
REQ-027 IDLE and NOP data_ids SHALL be passed through as ordinary short packets; dropping them is the downstream filter's job.

Reset
REQ-028 On reset low, all outputs SHALL be 0 and word_count/data_id SHALL be 0.
REQ-029 On reset low, the FSM SHALL be in HDR0, the counter at 0 and the CRC at 16'hFFFF.
REQ-030 A reset asserted mid-packet SHALL abandon the packet with no eop and no error pulse; parsing resumes at HDR0 on the first valid byte after release.

Structure
REQ-031 The header ecc function, CRC polynomial/init and FSM state encodings SHALL live in the shared slink_includes.vh alongside NOP_DATAID and IDL_SYM.
REQ-032 The CRC update SHALL be a combinational sub-module slink_crc16_8 with ports crc_in[15:0], data[7:0] and crc_out[15:0].
REQ-033 The FSM, counter and output registers SHALL stay in the top module.

Verification
REQ-034 Short packet: bytes 08,34,12,2E -> one cycle later sop=valid=eop=1, data_id=08, word_count=16'h1234, hdr_err=0.
REQ-035 Bad ecc: bytes 08,34,12,00 -> hdr_err single pulse, no sop; a following good short packet decodes normally.
REQ-036 Long packet: data_id 8'h40, wc=3, payload A1,B2,C3, correct CRC -> three valid cycles, sop on A1, eop on C3, crc_err=0.
REQ-037 Same long packet with CRC low byte flipped -> identical data stream plus one crc_err pulse after the CRC1 byte.
REQ-038 Long packet wc=3 with link_valid deasserted for 2 cycles between B2 and C3 -> valid gap of 2 cycles, eop still on C3, CRC correct.
REQ-039 Oversize/reset case: wc=16'd4097 -> hdr_err; separately, reset low during PAYLOAD then a short packet -> no eop for the aborted packet and the short packet decoded correctly.

Source files
------------

// File: rtl/slink_ll_rx_pkt_deframer_pkg.sv
// Shared definitions for the SLINK link-layer RX packet deframer.
//   - NOP_DATAID / IDL_SYM : reserved link symbols (passed through untouched)
//   - CRC16_POLY / INIT    : CRC-16/CCITT parameters for payload protection
//   - rx_state_t           : deframer FSM state encoding
//   - hdr_ecc()            : header check byte over data_id and word count
package slink_ll_rx_pkt_deframer_pkg;

    localparam logic [7:0]  NOP_DATAID = 8'h01;
    localparam logic [7:0]  IDL_SYM    = 8'h00;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_HDR0    = 3'd0,
        ST_HDR1    = 3'd1,
        ST_HDR2    = 3'd2,
        ST_HDR3    = 3'd3,
        ST_PAYLOAD = 3'd4,
        ST_CRC0    = 3'd5,
        ST_CRC1    = 3'd6
    } rx_state_t;

    function automatic logic [7:0] hdr_ecc(input logic [7:0] id,
                                           input logic [7:0] wc_lo,
                                           input logic [7:0] wc_hi);
        return id ^ wc_lo ^ wc_hi;
    endfunction

endpackage

// File: rtl/slink_crc16_8.sv
// Combinational CRC-16/CCITT update over one byte, MSB first.
//   crc_in  [15:0] : running CRC before this byte
//   data    [7:0]  : byte to fold in
//   crc_out [15:0] : running CRC after this byte
module slink_crc16_8
    import slink_ll_rx_pkt_deframer_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    logic [15:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[15] ^ data[7 - i];
            c  = {c[14:0], 1'b0};
            if (fb) begin
                c = c ^ CRC16_POLY;
            end
        end
        crc_out = c;
    end

endmodule

// File: rtl/slink_ll_rx_pkt_deframer.sv
// SLINK link-layer RX packet deframer.
// Parses the deskewed byte stream into packets: a 4-byte header
// (data_id, wc_lo, wc_hi, ecc), then for long packets wc payload bytes and a
// 2-byte CRC (low byte first). Emits a registered packet stream for the
// downstream filter.
//   clk, reset       : block clock, asynchronous active-low reset
//   link_data/valid  : RX byte stream; link_valid=0 stalls with state held
//   sop/valid/eop/data : packet stream (short packets: one beat, data=00)
//   data_id/word_count : header fields of the last good header
//   hdr_err/crc_err  : one-cycle error pulses
module slink_ll_rx_pkt_deframer
    import slink_ll_rx_pkt_deframer_pkg::*;
#(
    parameter logic [7:0]  SHORT_PKT_MAX_ID = 8'h1F,
    parameter logic [15:0] MAX_WORD_COUNT   = 16'd4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  link_data,
    input  logic        link_valid,
    output logic        sop,
    output logic [7:0]  data_id,
    output logic [15:0] word_count,
    output logic        valid,
    output logic [7:0]  data,
    output logic        eop,
    output logic        hdr_err,
    output logic        crc_err
);

    rx_state_t   state_q, state_d;

    logic [7:0]  id_q, id_d;
    logic [7:0]  wc_lo_q, wc_lo_d;
    logic [7:0]  wc_hi_q, wc_hi_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] crc_q, crc_d;
    logic [15:0] crc_next;

    logic        sop_q, sop_d;
    logic        valid_q, valid_d;
    logic        eop_q, eop_d;
    logic [7:0]  data_q, data_d;
    logic        hdr_err_q, hdr_err_d;
    logic        crc_err_q, crc_err_d;
    logic [7:0]  data_id_q, data_id_d;
    logic [15:0] word_count_q, word_count_d;

    logic [15:0] hdr_wc;
    logic        hdr_is_short;
    logic        hdr_ecc_ok;
    logic        hdr_oversize;
    logic        hdr_good;

    slink_crc16_8 u_crc (
        .crc_in  (crc_q),
        .data    (link_data),
        .crc_out (crc_next)
    );

    // Header decode; only meaningful while the ecc byte is on link_data in HDR3
    assign hdr_wc       = {wc_hi_q, wc_lo_q};
    assign hdr_is_short = (id_q <= SHORT_PKT_MAX_ID);
    assign hdr_ecc_ok   = (link_data == hdr_ecc(id_q, wc_lo_q, wc_hi_q));
    assign hdr_oversize = !hdr_is_short && (hdr_wc > MAX_WORD_COUNT);
    assign hdr_good     = hdr_ecc_ok && !hdr_oversize;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HDR0;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (link_valid) begin
            unique case (state_q)
                ST_HDR0: state_d = ST_HDR1;
                ST_HDR1: state_d = ST_HDR2;
                ST_HDR2: state_d = ST_HDR3;
                ST_HDR3: begin
                    if (!hdr_good || hdr_is_short) begin
                        state_d = ST_HDR0;
                    end else if (hdr_wc == 16'd0) begin
                        state_d = ST_CRC0;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (cnt_q == 16'd1) begin
                        state_d = ST_CRC0;
                    end
                end
                ST_CRC0: state_d = ST_CRC1;
                ST_CRC1: state_d = ST_HDR0;
                default: state_d = ST_HDR0;
            endcase
        end
    end

    // Datapath and output logic
    always_comb begin
        id_d         = id_q;
        wc_lo_d      = wc_lo_q;
        wc_hi_d      = wc_hi_q;
        crc_lo_d     = crc_lo_q;
        cnt_d        = cnt_q;
        crc_d        = crc_q;
        data_id_d    = data_id_q;
        word_count_d = word_count_q;
        sop_d        = 1'b0;
        valid_d      = 1'b0;
        eop_d        = 1'b0;
        data_d       = 8'h00;
        hdr_err_d    = 1'b0;
        crc_err_d    = 1'b0;

        if (link_valid) begin
            unique case (state_q)
                ST_HDR0: id_d    = link_data;
                ST_HDR1: wc_lo_d = link_data;
                ST_HDR2: wc_hi_d = link_data;
                ST_HDR3: begin
                    cnt_d = hdr_wc;
                    crc_d = CRC16_INIT;
                    if (!hdr_good) begin
                        hdr_err_d = 1'b1;
                    end else begin
                        data_id_d    = id_q;
                        word_count_d = hdr_wc;
                        if (hdr_is_short) begin
                            sop_d   = 1'b1;
                            valid_d = 1'b1;
                            eop_d   = 1'b1;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    // word_count_q holds this packet's wc, so the counter
                    // still equals it only on the first payload byte
                    valid_d = 1'b1;
                    data_d  = link_data;
                    sop_d   = (cnt_q == word_count_q);
                    eop_d   = (cnt_q == 16'd1);
                    cnt_d   = cnt_q - 16'd1;
                    crc_d   = crc_next;
                end
                ST_CRC0: crc_lo_d = link_data;
                ST_CRC1: begin
                    crc_err_d = ({link_data, crc_lo_q} != crc_q);
                    // Zero-length long packet is reported once its CRC is in
                    if (word_count_q == 16'd0) begin
                        sop_d   = 1'b1;
                        valid_d = 1'b1;
                        eop_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_q         <= '0;
            wc_lo_q      <= '0;
            wc_hi_q      <= '0;
            crc_lo_q     <= '0;
            cnt_q        <= '0;
            crc_q        <= CRC16_INIT;
            data_id_q    <= '0;
            word_count_q <= '0;
            sop_q        <= 1'b0;
            valid_q      <= 1'b0;
            eop_q        <= 1'b0;
            data_q       <= '0;
            hdr_err_q    <= 1'b0;
            crc_err_q    <= 1'b0;
        end else begin
            id_q         <= id_d;
            wc_lo_q      <= wc_lo_d;
            wc_hi_q      <= wc_hi_d;
            crc_lo_q     <= crc_lo_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            data_id_q    <= data_id_d;
            word_count_q <= word_count_d;
            sop_q        <= sop_d;
            valid_q      <= valid_d;
            eop_q        <= eop_d;
            data_q       <= data_d;
            hdr_err_q    <= hdr_err_d;
            crc_err_q    <= crc_err_d;
        end
    end

    assign sop        = sop_q;
    assign valid      = valid_q;
    assign eop        = eop_q;
    assign data       = data_q;
    assign hdr_err    = hdr_err_q;
    assign crc_err    = crc_err_q;
    assign data_id    = data_id_q;
    assign word_count = word_count_q;

endmodule
